// File: rtl/stage_object_scanner_if.sv
// Stream/bus bundle between the stage generator buses, the scanner and its consumer.
// The master modport is the scanner side; slave is the driver/consumer side.
interface stage_object_scanner_if #(
    parameter int unsigned N  = 64,
    parameter int unsigned W  = 13,
    parameter int unsigned SW = 2,
    parameter int unsigned IW = 6
);
    logic              start;
    logic [W-1:0]      camera_x;
    logic [N*W-1:0]    obj_x;
    logic [N*W-1:0]    obj_y;
    logic [N*SW-1:0]   obj_state;
    logic              out_valid;
    logic              out_ready;
    logic [IW-1:0]     out_index;
    logic [W:0]        out_x;
    logic [W-1:0]      out_y;
    logic [SW-1:0]     out_state;
    logic              busy;
    logic              done;
    logic [IW:0]       count;

    modport master (
        input  start, camera_x, obj_x, obj_y, obj_state, out_ready,
        output out_valid, out_index, out_x, out_y, out_state, busy, done, count
    );

    modport slave (
        output start, camera_x, obj_x, obj_y, obj_state, out_ready,
        input  out_valid, out_index, out_x, out_y, out_state, busy, done, count
    );
endinterface

// File: rtl/stage_object_scanner.sv
// Walks the packed stage-object slots one per cycle and streams out every slot
// inside the camera window, with x converted to screen-relative coordinates.
module stage_object_scanner #(
    parameter int unsigned N      = 64,
    parameter int unsigned W      = 13,
    parameter int unsigned SW     = 2,
    parameter int unsigned IW     = 6,
    parameter int unsigned VIEW_W = 640,
    parameter int unsigned OBJ_W  = 40
) (
    input logic                    clk,
    input logic                    rst,
    stage_object_scanner_if.master bus
);
    localparam int unsigned W1 = W + 1;
    localparam int unsigned CW = IW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    cam_q, cam_d;
    logic            out_valid_q, out_valid_d;
    logic [IW-1:0]   out_index_q, out_index_d;
    logic [W1-1:0]   out_x_q, out_x_d;
    logic [W-1:0]    out_y_q, out_y_d;
    logic [SW-1:0]   out_state_q, out_state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CW-1:0]   count_q, count_d;

    logic [W-1:0]    slot_x, slot_y;
    logic [SW-1:0]   slot_state;
    logic [W1-1:0]   x_ext, cam_ext;
    logic            slot_enabled, slot_visible, out_free;

    // Current slot fields and the one-extra-bit window compare (no wrap near 2^W-1)
    always_comb begin
        slot_x       = bus.obj_x[32'(idx_q) * W +: W];
        slot_y       = bus.obj_y[32'(idx_q) * W +: W];
        slot_state   = bus.obj_state[32'(idx_q) * SW +: SW];
        x_ext        = {1'b0, slot_x};
        cam_ext      = {1'b0, cam_q};
        slot_enabled = (slot_x != '0) || (slot_y != '0);
        slot_visible = slot_enabled
                    && ((x_ext + W1'(OBJ_W)) > cam_ext)
                    && (x_ext < (cam_ext + W1'(VIEW_W)));
        out_free     = !out_valid_q || bus.out_ready;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cam_d       = cam_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_state_d = out_state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        count_d     = count_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cam_d   = bus.camera_x;
                    idx_d   = '0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                // A stalled consumer freezes the walk so no entry is lost
                if (out_free) begin
                    if (slot_visible) begin
                        out_valid_d = 1'b1;
                        out_index_d = idx_q;
                        out_x_d     = x_ext - cam_ext;
                        out_y_d     = slot_y;
                        out_state_d = slot_state;
                        count_d     = count_q + CW'(1);
                    end else begin
                        out_valid_d = 1'b0;
                    end
                    idx_d = idx_q + IW'(1);
                    if (idx_q == IW'(N - 1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_free) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cam_q       <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_state_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cam_q       <= cam_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_state_q <= out_state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            count_q     <= count_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_index = out_index_q;
    assign bus.out_x     = out_x_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_state = out_state_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_stage_object_scanner.sv
// Self-checking bench for stage_object_scanner: vector table of single-slot window
// cases, a scoreboard of expected entries, and sequences for stall/empty/reset.
module tb_stage_object_scanner;
    localparam int N  = 64;
    localparam int W  = 13;
    localparam int SW = 2;
    localparam int IW = 6;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    stage_object_scanner_if #(.N(N), .W(W), .SW(SW), .IW(IW)) bus ();

    stage_object_scanner #(.N(N), .W(W), .SW(SW), .IW(IW), .VIEW_W(640), .OBJ_W(40)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic [13:0] x;
        logic [12:0] y;
        logic [1:0]  st;
    } exp_t;

    typedef struct {
        int          slot;
        logic [12:0] cam;
        logic [12:0] x;
        logic [12:0] y;
        logic [1:0]  st;
        bit          vis;
        logic [13:0] ex;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   done_seen = 0;
    int   valid_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_slots();
        bus.obj_x     = '0;
        bus.obj_y     = '0;
        bus.obj_state = '0;
    endtask

    task automatic set_slot(input int i, input logic [12:0] x, input logic [12:0] y, input logic [1:0] st);
        bus.obj_x[i*W +: W]      = x;
        bus.obj_y[i*W +: W]      = y;
        bus.obj_state[i*SW +: SW] = st;
    endtask

    task automatic push(input int i, input logic [13:0] x, input logic [12:0] y, input logic [1:0] st);
        exp_t e;
        e.idx = i; e.x = x; e.y = y; e.st = st;
        sb.push_back(e);
    endtask

    // Output monitor: pops scoreboard on each handshake, checks stability while stalled
    exp_t        m_e;
    bit          hold_v = 1'b0;
    logic [5:0]  h_idx;
    logic [13:0] h_x;
    logic [12:0] h_y;
    logic [1:0]  h_st;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (bus.done) done_seen++;
            if (bus.out_valid) valid_seen++;
            if (hold_v && bus.out_valid) begin
                chk("stall_hold", {bus.out_index, bus.out_x, bus.out_y, bus.out_state},
                    {h_idx, h_x, h_y, h_st});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_entry_idx", 64'(bus.out_index), 64'hFFFF);
                end else begin
                    m_e = sb.pop_front();
                    chk("entry_idx", 64'(bus.out_index), 64'(m_e.idx));
                    chk("entry_x", 64'(bus.out_x), 64'(m_e.x));
                    chk("entry_y", 64'(bus.out_y), 64'(m_e.y));
                    chk("entry_state", 64'(bus.out_state), 64'(m_e.st));
                end
            end
            hold_v = bus.out_valid && !bus.out_ready;
            h_idx = bus.out_index; h_x = bus.out_x; h_y = bus.out_y; h_st = bus.out_state;
        end
    end

    task automatic run_scan(input logic [12:0] cam, input int exp_cnt, input int stall);
        int s;
        int dc;
        bit got;
        bus.camera_x = cam;
        bus.start    = 1'b1;
        if (stall > 0) bus.out_ready = 1'b0;
        s = cyc;
        tick();
        bus.start    = 1'b0;
        bus.camera_x = ~cam;
        if (stall > 0) begin
            got = 1'b0;
            for (int i = 0; i < 4 * N && !got; i++) begin
                @(negedge clk);
                if (bus.out_valid) got = 1'b1;
            end
            chk("stall_first_valid", 64'(got), 64'd1);
            repeat (stall) @(negedge clk);
            tick();
            bus.out_ready = 1'b1;
        end
        got = 1'b0;
        dc  = 0;
        for (int i = 0; i < 4 * N && !got; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                dc  = cyc;
            end
        end
        chk("done_reached", 64'(got), 64'd1);
        if (stall == 0) chk("done_latency_ok", 64'((dc - s == N + 1) || (dc - s == N + 2)), 64'd1);
        chk("count", 64'(bus.count), 64'(exp_cnt));
        chk("busy_after_done", 64'(bus.busy), 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        tick();
        chk("count_holds", 64'(bus.count), 64'(exp_cnt));
        chk("done_one_cycle", 64'(bus.done), 64'd0);
    endtask

    vec_t vecs[12];

    initial begin
        int  d0;
        int  v0;
        int  s;
        int  dc;
        bit  got;

        vecs[0]  = '{0,  13'd480,  13'd1080, 13'd439, 2'd1, 1'b1, 14'd600};
        vecs[1]  = '{0,  13'd480,  13'd1120, 13'd5,   2'd1, 1'b0, 14'd0};
        vecs[2]  = '{0,  13'd450,  13'd440,  13'd7,   2'd2, 1'b1, 14'h3FF6};
        vecs[3]  = '{0,  13'd450,  13'd410,  13'd7,   2'd2, 1'b0, 14'd0};
        vecs[4]  = '{7,  13'd450,  13'd411,  13'd9,   2'd3, 1'b1, 14'h3FD9};
        vecs[5]  = '{63, 13'd0,    13'd639,  13'd11,  2'd1, 1'b1, 14'd639};
        vecs[6]  = '{63, 13'd0,    13'd640,  13'd11,  2'd1, 1'b0, 14'd0};
        vecs[7]  = '{30, 13'd8191, 13'd8190, 13'd1,   2'd2, 1'b1, 14'h3FFF};
        vecs[8]  = '{30, 13'd8000, 13'd100,  13'd1,   2'd2, 1'b0, 14'd0};
        vecs[9]  = '{5,  13'd0,    13'd0,    13'd0,   2'd3, 1'b0, 14'd0};
        vecs[10] = '{5,  13'd0,    13'd0,    13'd5,   2'd3, 1'b1, 14'd0};
        vecs[11] = '{12, 13'd7800, 13'd8191, 13'd4095, 2'd0, 1'b1, 14'd391};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.camera_x = '0;
        bus.out_ready = 1'b1;
        clear_slots();
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_fields", {bus.out_index, bus.out_x, bus.out_y, bus.out_state}, 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_count", 64'(bus.count), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single-slot window cases
        foreach (vecs[k]) begin
            clear_slots();
            set_slot(vecs[k].slot, vecs[k].x, vecs[k].y, vecs[k].st);
            if (vecs[k].vis) push(vecs[k].slot, vecs[k].ex, vecs[k].y, vecs[k].st);
            run_scan(vecs[k].cam, vecs[k].vis ? 1 : 0, 0);
        end

        // Two adjacent visible slots
        clear_slots();
        set_slot(0, 13'd320, 13'd359, 2'd3);
        set_slot(1, 13'd360, 13'd359, 2'd0);
        push(0, 14'd320, 13'd359, 2'd3);
        push(1, 14'd360, 13'd359, 2'd0);
        run_scan(13'd0, 2, 0);

        // Consumer stall on the first of three entries
        clear_slots();
        set_slot(2, 13'd100, 13'd1, 2'd1);
        set_slot(3, 13'd200, 13'd2, 2'd2);
        set_slot(9, 13'd639, 13'd3, 2'd3);
        push(2, 14'd100, 13'd1, 2'd1);
        push(3, 14'd200, 13'd2, 2'd2);
        push(9, 14'd639, 13'd3, 2'd3);
        run_scan(13'd0, 3, 5);

        // Empty scan with a second start while busy
        clear_slots();
        d0 = done_seen;
        v0 = valid_seen;
        bus.camera_x = 13'd0;
        bus.start = 1'b1;
        s = cyc;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        got = 1'b0;
        dc  = 0;
        for (int i = 0; i < 4 * N && !got; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                dc  = cyc;
            end
        end
        chk("empty_done_reached", 64'(got), 64'd1);
        chk("empty_done_latency_ok", 64'((dc - s == N + 1) || (dc - s == N + 2)), 64'd1);
        chk("empty_count", 64'(bus.count), 64'd0);
        repeat (N + 10) tick();
        chk("empty_single_done", 64'(done_seen - d0), 64'd1);
        chk("empty_no_valid", 64'(valid_seen - v0), 64'd0);
        chk("empty_idle_busy", 64'(bus.busy), 64'd0);

        // Reset asserted mid-scan with a stalled entry
        clear_slots();
        for (int i = 0; i < 10; i++) set_slot(i, 13'(50 + i), 13'd1, 2'd1);
        bus.out_ready = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.out_valid) got = 1'b1;
        end
        chk("midscan_valid_up", 64'(got), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midscan_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("midscan_rst_busy", 64'(bus.busy), 64'd0);
        chk("midscan_rst_fields", {bus.out_index, bus.out_x, bus.out_y, bus.out_state}, 64'd0);
        sb.delete();
        repeat (2) tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        clear_slots();
        set_slot(5, 13'd300, 13'd4, 2'd2);
        set_slot(20, 13'd10, 13'd9, 2'd1);
        push(5, 14'd300, 13'd4, 2'd2);
        push(20, 14'd10, 13'd9, 2'd1);
        run_scan(13'd0, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stage_object_scanner.md
Name: stage_object_scanner

Overview:
- Reader side of the packed stage-object buses that the stage generator drives (x/y/state per slot, 13-bit fields, slot disabled when {x,y}=0).
- On `start`, walks one slot per cycle and skips disabled slots. Emits each slot that falls inside the current camera window, one at a time, over a valid/ready stream.
- The emitted x is screen-relative. Sits between the stage generator and the renderer/collision logic.

Parameters:
- N, 64, number of slots in the packed buses
- W, 13, coordinate field width
- SW, 2, state field width per slot
- IW, 6, index width (clog2(N))
- VIEW_W, 640, camera window width in pixels
- OBJ_W, 40, object width used for the partial-visibility test

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  pulse: begin a scan; ignored while busy=1
- camera_x  in  W  world x of the left screen edge; sampled on accepted start
- obj_x  in  N*W  packed x, slot i at [i*W +: W]
- obj_y  in  N*W  packed y, same layout
- obj_state  in  N*SW  packed state, slot i at [i*SW +: SW]
- out_valid  out  1  output entry valid
- out_ready  in  1  consumer accepts entry when out_valid&&out_ready
- out_index  out  IW  slot number of the entry
- out_x  out  W+1  screen x = obj_x - cam, two's complement signed
- out_y  out  W  obj_y passed through
- out_state  out  SW  slot state passed through
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of scan
- count  out  IW+1  number of entries emitted in the last scan

Behaviour:
- Reset (async, any time, including mid-scan):
  - state=IDLE; idx=0; cam=0.
  - out_valid=0, out_index=0, out_x=0, out_y=0, out_state=0.
  - busy=0, done=0, count=0.
- FSM IDLE:
  - start=1 → latch cam=camera_x, idx=0, count=0, busy=1 → SCAN.
- FSM SCAN, one slot evaluated per cycle while the output register is free:
  - Output register is free when out_valid=0 or (out_valid&&out_ready).
  - Slot i is enabled when !(x==0 && y==0).
  - Slot i is visible when enabled && x+OBJ_W > cam && x < cam+VIEW_W.
  - Compare arithmetic is unsigned, W+1 bits wide, so there is no overflow at cam near 2^W-1.
  - If visible: load the output register next cycle (out_valid=1, out_index=i, out_x=x-cam (W+1 bits), out_y, out_state) and increment count.
  - If not visible: skip; out_valid falls if the previous entry was just accepted.
  - Free register: idx increments every cycle.
  - Not free (out_valid && !out_ready): idx and all outputs hold (stall).
  - After evaluating idx=N-1 → DRAIN.
- FSM DRAIN:
  - Wait until out_valid=0 or (out_valid&&out_ready).
  - Then clear out_valid, pulse done=1 for one cycle, busy=0 → IDLE.
- Latency: with out_ready tied high, slot i is evaluated in cycle start+1+i, and its entry is visible in cycle start+2+i.
  - Full scan with no stalls: done is high in cycle start+N+1 or start+N+2.
- Output stability: out_index/out_x/out_y/out_state stay stable while out_valid=1 and out_ready=0.
- Inputs obj_* must stay static during a scan; a camera_x change mid-scan has no effect (cam is latched).
- start while busy: ignored; it does not restart or extend the scan.
- Empty result (no visible slots): done still pulses, count=0, out_valid never rises.
- count holds its value from done until the next accepted start.
- Boundaries:
  - x = cam+VIEW_W → invisible.
  - x+OBJ_W = cam → invisible.
  - x = cam-1 → visible, out_x=-1 (all ones).

Test Plan:
- Slot0 (320,359,3), slot1 (360,359,0), rest 0; cam=0; out_ready=1 → two entries:
  - idx0 out_x=320 state=3; idx1 out_x=360 state=0.
  - count=2; done in cycle start+N+1 or start+N+2.
- Slot0 x=1080 y=439, cam=480: visible, out_x=600. Then x=1120, cam=480 → invisible (1120 = cam+VIEW_W), not emitted.
- Slot0 x=440, cam=450 → visible, out_x=-10 (0x3FF6 at W+1=14 bits). Slot0 x=410, cam=450 → invisible (x+OBJ_W = cam).
- Three visible slots, out_ready low for 5 cycles on the first entry:
  - Outputs hold steady during the stall; no entry is lost or duplicated; order is preserved.
  - Final count=3.
- All slots zero → no out_valid; done pulses once; count=0. A second start during busy has no effect.
- Assert rst mid-scan with out_valid=1 → outputs immediately 0, busy=0. A following start rescans from idx=0 correctly.
